// File: rtl/layer8_argmax.sv
// layer8_argmax: captures ten signed class scores and scans them sequentially for the largest
module layer8_argmax #(
    parameter int WORDLENGTH = 16,
    parameter int CLASS_NUM  = 10,
    parameter int IDX_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WORDLENGTH*CLASS_NUM-1:0] logits_in,
    input  logic                           logits_valid,
    input  logic                           result_ready,
    output logic                           result_valid,
    output logic [IDX_W-1:0]               result_idx,
    output logic [WORDLENGTH-1:0]          result_score,
    output logic                           busy,
    output logic                           overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t state;
    logic signed [WORDLENGTH-1:0] score_buf [CLASS_NUM];
    logic signed [WORDLENGTH-1:0] max_q;
    logic signed [WORDLENGTH-1:0] cur;
    logic [IDX_W-1:0] cnt, idx;
    assign cur  = score_buf[cnt];
    assign busy = state != IDLE;
    // score buffer: loaded only on the capture edge so later logits_in changes cannot disturb a scan
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int c = 0; c < CLASS_NUM; c++) score_buf[c] <= '0;
        else if (state == IDLE && logits_valid)
            for (int c = 0; c < CLASS_NUM; c++) score_buf[c] <= logits_in[c*WORDLENGTH +: WORDLENGTH];
    end
    // capture / one-compare-per-cycle scan / hold-until-accepted, with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            max_q        <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_score <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= logits_valid && state != IDLE;
            case (state)
                IDLE: if (logits_valid) begin
                    max_q <= logits_in[WORDLENGTH-1:0];
                    idx   <= '0;
                    cnt   <= IDX_W'(1);
                    state <= SCAN;
                end
                SCAN: begin
                    if (cur > max_q) begin
                        max_q <= cur;
                        idx   <= cnt;
                    end
                    cnt   <= cnt == IDX_W'(CLASS_NUM-1) ? '0 : cnt + 1'b1;
                    state <= cnt == IDX_W'(CLASS_NUM-1) ? HOLD : SCAN;
                end
                HOLD: if (result_valid && result_ready) begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end else begin
                    result_valid <= 1'b1;
                    result_idx   <= idx;
                    result_score <= max_q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer8_argmax.sv
// tb_layer8_argmax: directed scenario tests for the layer-8 argmax stage
module tb_layer8_argmax;
    localparam int W = 16;
    localparam int N = 10;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W*N-1:0] logits_in = '0;
    logic           logits_valid = 1'b0;
    logic           result_ready = 1'b1;
    logic           result_valid;
    logic [3:0]     result_idx;
    logic [W-1:0]   result_score;
    logic           busy;
    logic           overrun;
    int checks = 0;
    int failures = 0;
    int v[N];
    int cyc;

    layer8_argmax dut (
        .clk(clk), .rst(rst), .logits_in(logits_in), .logits_valid(logits_valid),
        .result_ready(result_ready), .result_valid(result_valid), .result_idx(result_idx),
        .result_score(result_score), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W*N-1:0] pack(input int s[N]);
        logic [W*N-1:0] r;
        for (int c = 0; c < N; c++) r[c*W +: W] = W'(s[c]);
        return r;
    endfunction

    // called just after a posedge; the following posedge is the capture edge
    task automatic strobe(input logic [W*N-1:0] x);
        logits_in = x;
        logits_valid = 1'b1;
        @(posedge clk); #1;
        logits_valid = 1'b0;
    endtask

    // cycles from capture edge until result_valid is seen; 0 on timeout
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b exp 0", result_valid); end
        checks++; if (result_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got %0d exp 0", result_idx); end
        checks++; if (result_score !== 16'd0) begin failures++; $display("FAIL reset_score got %0h exp 0", result_score); end
        checks++; if ({busy, overrun} !== 2'b00) begin failures++; $display("FAIL reset_busy_overrun got %b exp 00", {busy, overrun}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ascending;
        for (int c = 0; c < N; c++) v[c] = c;
        result_ready = 1'b1;
        strobe(pack(v));
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL asc_busy got %0b exp 1", busy); end
        wait_valid(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL asc_latency got %0d exp 10", cyc); end
        checks++; if (result_idx !== 4'd9) begin failures++; $display("FAIL asc_idx got %0d exp 9", result_idx); end
        checks++; if (result_score !== 16'd9) begin failures++; $display("FAIL asc_score got %0h exp 9", result_score); end
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL asc_valid_width got %0b exp 0", result_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL asc_idle got %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -9};
        strobe(pack(v));
        checks++; if ({busy, overrun} !== 2'b10) begin failures++; $display("FAIL b2b_capture got %b exp 10", {busy, overrun}); end
        wait_valid(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL b2b_latency got %0d exp 10", cyc); end
        checks++; if (result_idx !== 4'd8 || result_score !== 16'd9) begin failures++; $display("FAIL b2b_result got %0d/%0h exp 8/9", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie;
        v = '{5, -3, 7, 7, 2, 0, 0, 0, 0, 0};
        strobe(pack(v));
        wait_valid(cyc);
        checks++; if (result_idx !== 4'd2 || result_score !== 16'd7) begin failures++; $display("FAIL tie_result got %0d/%0h exp 2/7", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_all_min;
        for (int c = 0; c < N; c++) v[c] = -32768;
        strobe(pack(v));
        wait_valid(cyc);
        checks++; if (result_idx !== 4'd0 || result_score !== 16'h8000) begin failures++; $display("FAIL min_result got %0d/%0h exp 0/8000", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_negative;
        v = '{-1, -200, -5, -1000, -2, -3, -4, -6, -7, -8};
        strobe(pack(v));
        wait_valid(cyc);
        checks++; if (result_idx !== 4'd0 || result_score !== 16'hFFFF) begin failures++; $display("FAIL neg_result got %0d/%0h exp 0/ffff", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int bad;
        v = '{1, 2, 3, 4, 100, 5, 6, 7, 8, 9};
        result_ready = 1'b0;
        strobe(pack(v));
        wait_valid(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL bp_latency got %0d exp 10", cyc); end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || result_idx !== 4'd4 || result_score !== 16'd100) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable got %0d unstable cycles exp 0", bad); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL bp_release got %0b exp 0", result_valid); end
        checks++; if (result_idx !== 4'd4 || result_score !== 16'd100) begin failures++; $display("FAIL bp_retain got %0d/%0h exp 4/64", result_idx, result_score); end
    endtask

    task automatic test_overrun;
        v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        strobe(pack(v));
        for (int c = 0; c < N; c++) v[c] = 30000 - c;
        logits_in = pack(v);
        @(posedge clk); #1;
        @(posedge clk); #1;
        logits_valid = 1'b1;
        @(posedge clk); #1;
        logits_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got %0b exp 1", overrun); end
        @(posedge clk); #1;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_single got %0b exp 0", overrun); end
        wait_valid(cyc);
        checks++; if (cyc !== 6) begin failures++; $display("FAIL ovr_latency got %0d exp 6", cyc); end
        checks++; if (result_idx !== 4'd5 || result_score !== 16'd9) begin failures++; $display("FAIL ovr_result got %0d/%0h exp 5/9", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        v = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        strobe(pack(v));
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++; if ({result_valid, busy, overrun} !== 3'b000) begin failures++; $display("FAIL mid_flags got %b exp 000", {result_valid, busy, overrun}); end
        checks++; if (result_idx !== 4'd0 || result_score !== 16'd0) begin failures++; $display("FAIL mid_result got %0d/%0h exp 0/0", result_idx, result_score); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got %0b exp 0", result_valid); end
        v = '{0, 0, 0, -5, 0, 0, 50, 0, 0, 0};
        strobe(pack(v));
        wait_valid(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL mid_latency got %0d exp 10", cyc); end
        checks++; if (result_idx !== 4'd6 || result_score !== 16'd50) begin failures++; $display("FAIL mid_result2 got %0d/%0h exp 6/32", result_idx, result_score); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_back_to_back;
        test_tie;
        test_all_min;
        test_negative;
        test_backpressure;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
